mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage. Consumes EX results: aluop, effective address, store data, writeback fields.
- Performs LoongArch ld.b/h/w/bu/hu and st.b/h/w over a word-wide request/acknowledge data bus.
- Aligns and extends load data, passes non-memory results through, and hands a registered result to writeback.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, data bus width; fixed at 32, byte lanes = 4.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid_i  in  1  EX result valid this cycle
- in_ready_o  out  1  stage can accept EX result
- aluop_i  in  8  operation code (AluOpBus)
- mem_addr_i  in  32  effective address from EX
- reg2_i  in  32  store data
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  32  EX result for non-memory ops
- inst_pc_i  in  32  instruction PC
- flush_i  in  1  kill in-flight/incoming op (branch/exception)
- dbus_req_o  out  1  bus request, held until ack
- dbus_we_o  out  1  1 = store
- dbus_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- dbus_wstrb_o  out  4  byte strobes (0 for loads)
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_rdata_i  in  32  load data, valid with ack
- dbus_ack_i  in  1  transaction complete
- out_valid_o  out  1  one-cycle pulse, result valid to WB
- wd_o  out  5
- wreg_o  out  1
- wdata_o  out  32
- inst_pc_o  out  32
- ale_o  out  1  address-misaligned exception flag with out_valid_o
- stallreq_o  out  1  = ~in_ready_o, to pipeline control

Behaviour:
- Reset (rst=0, async): state IDLE; out_valid_o, wreg_o, ale_o, dbus_req_o, dbus_we_o = 0; all data/address outputs = 0.
- FSM states: IDLE, BUSY, DRAIN.
- in_ready_o = (state==IDLE).
- IDLE, accept (in_valid_i & ~flush_i):
  - Non-memory op: register wd/wreg/wdata/pc; out_valid_o=1 next cycle (latency 1). Stay IDLE.
  - Misaligned memory op (half with addr[0]=1, word with addr[1:0]!=0): no bus request. Next cycle out_valid_o=1, ale_o=1, wreg_o=0.
  - Aligned memory op: latch op, addr[1:0], wd, wreg, pc. Assert dbus_req_o with addr/we/wstrb/wdata from next cycle. Go BUSY.
- BUSY:
  - dbus_req_o and all bus outputs held stable until dbus_ack_i.
  - On ack: dbus_req_o=0 next cycle, out_valid_o=1 next cycle, return IDLE.
  - Minimum memory-op latency: accept→req 1 cycle, ack ≥1 cycle after req, result 1 cycle after ack.
- Load extraction: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16].
  - ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend; ld.w unchanged.
- Stores:
  - st.b: wstrb = 4'b0001<<addr[1:0], wdata = {4{reg2[7:0]}}.
  - st.h: wstrb = 4'b0011<<{addr[1],1'b0}, wdata = {2{reg2[15:0]}}.
  - st.w: wstrb = 4'b1111.
  - Store result: wreg_o=0.
- flush_i:
  - In IDLE: incoming op dropped, no out_valid_o.
  - In BUSY without same-cycle ack: go DRAIN. Bus request cannot be withdrawn; keep req held until ack, then discard data, no out_valid_o, then IDLE.
  - In BUSY with same-cycle ack: result discarded, go IDLE.
  - Flush also cancels a pending out_valid_o for the next cycle.
- Stores already acknowledged are never undone by flush.
- Reset mid-transaction: returns to IDLE immediately, dbus_req_o drops; any late ack is ignored.
- out_valid_o is never high for two consecutive results without an intervening accept; WB always accepts.

Decomposition:
- Shared defines: EXE_LD_B/H/W/BU/HU_OP and EXE_ST_B/H/W_OP aluop codes, AluOpBus/RegBus widths, state encoding localparams.
- Natural sub-module: mem_align, combinational. Inputs: op, addr[1:0], reg2, rdata. Outputs: wstrb, wdata, extended load result, misaligned flag.

Test Plan:
- Non-memory pass-through: add, wdata_i=0x12345678, wd=5, wreg=1 → one cycle later out_valid_o=1, wdata_o=0x12345678, wd_o=5; no dbus_req_o.
- ld.b, addr=0x1003, rdata=0x80FF7F01, ack 3 cycles after req → wdata_o=0xFFFFFF80. Same with ld.bu → 0x00000080. dbus_addr_o=0x1000, in_ready_o=0 throughout BUSY.
- st.h, addr=0x2002, reg2=0xAAAA1234 → dbus_we_o=1, wstrb=4'b1100, wdata=0x12341234; req held stable until ack; out_valid_o with wreg_o=0.
- ld.w, addr=0x3001 → no bus request; next cycle out_valid_o=1, ale_o=1, wreg_o=0.
- ld.w in BUSY, flush_i pulsed before ack → state DRAIN, req held until ack, no out_valid_o, in_ready_o=1 cycle after ack.
- Assert rst=0 asynchronously during BUSY → dbus_req_o=0 and out_valid_o=0 without a clock edge; a subsequent stray ack produces no output.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, LoongArch load/store aluop codes and FSM encoding for the memory stage.
package mem_stage_pkg;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int ALUOP_BUS_W = 8;
    localparam int REG_BUS_W   = 32;
    localparam int REG_ADDR_W  = 5;

    localparam logic [ALUOP_BUS_W-1:0] EXE_ADD_OP   = 8'h10;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LD_B_OP  = 8'h30;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LD_H_OP  = 8'h31;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LD_W_OP  = 8'h32;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LD_BU_OP = 8'h33;
    localparam logic [ALUOP_BUS_W-1:0] EXE_LD_HU_OP = 8'h34;
    localparam logic [ALUOP_BUS_W-1:0] EXE_ST_B_OP  = 8'h38;
    localparam logic [ALUOP_BUS_W-1:0] EXE_ST_H_OP  = 8'h39;
    localparam logic [ALUOP_BUS_W-1:0] EXE_ST_W_OP  = 8'h3a;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic is_store_op(input logic [ALUOP_BUS_W-1:0] op);
        return op inside {EXE_ST_B_OP, EXE_ST_H_OP, EXE_ST_W_OP};
    endfunction

    function automatic logic is_mem_op(input logic [ALUOP_BUS_W-1:0] op);
        return is_store_op(op) || (op inside {EXE_LD_B_OP, EXE_LD_H_OP, EXE_LD_W_OP, EXE_LD_BU_OP, EXE_LD_HU_OP});
    endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: word-wide request/acknowledge data bus between the memory stage and memory.
interface mem_stage_if;
    import mem_stage_pkg::*;
    logic              dbus_req_o;
    logic              dbus_we_o;
    logic [ADDR_W-1:0] dbus_addr_o;
    logic [3:0]        dbus_wstrb_o;
    logic [DATA_W-1:0] dbus_wdata_o;
    logic [DATA_W-1:0] dbus_rdata_i;
    logic              dbus_ack_i;

    modport master (
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wstrb_o, dbus_wdata_o,
        input  dbus_rdata_i, dbus_ack_i
    );
    modport slave (
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wstrb_o, dbus_wdata_o,
        output dbus_rdata_i, dbus_ack_i
    );
endinterface

// File: rtl/mem_stage_align.sv
// mem_align: byte-lane steering for stores, load extraction/extension and misalignment detection.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [ALUOP_BUS_W-1:0] op_i,
    input  logic [1:0]             addr_i,
    input  logic [REG_BUS_W-1:0]   reg2_i,
    input  logic [DATA_W-1:0]      rdata_i,
    output logic [3:0]             wstrb_o,
    output logic [DATA_W-1:0]      wdata_o,
    output logic [REG_BUS_W-1:0]   ldata_o,
    output logic                   misaligned_o
);
    logic [7:0]  lb;
    logic [15:0] lh;
    logic        half, word;

    assign lb   = rdata_i[{addr_i, 3'b000} +: 8];
    assign lh   = rdata_i[{addr_i[1], 4'b0000} +: 16];
    assign half = op_i inside {EXE_LD_H_OP, EXE_LD_HU_OP, EXE_ST_H_OP};
    assign word = op_i inside {EXE_LD_W_OP, EXE_ST_W_OP};
    assign misaligned_o = (half & addr_i[0]) | (word & (addr_i != 2'b00));

    assign wstrb_o = op_i == EXE_ST_B_OP ? 4'b0001 << addr_i
                   : op_i == EXE_ST_H_OP ? 4'b0011 << {addr_i[1], 1'b0}
                   : op_i == EXE_ST_W_OP ? 4'b1111 : 4'b0000;
    assign wdata_o = op_i == EXE_ST_B_OP ? {4{reg2_i[7:0]}}
                   : op_i == EXE_ST_H_OP ? {2{reg2_i[15:0]}}
                   : op_i == EXE_ST_W_OP ? reg2_i : '0;
    assign ldata_o = op_i == EXE_LD_B_OP  ? {{24{lb[7]}}, lb}
                   : op_i == EXE_LD_BU_OP ? {24'b0, lb}
                   : op_i == EXE_LD_H_OP  ? {{16{lh[15]}}, lh}
                   : op_i == EXE_LD_HU_OP ? {16'b0, lh}
                   : op_i == EXE_LD_W_OP  ? rdata_i : '0;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: LoongArch load/store stage over a req/ack data bus with a registered one-cycle WB result.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [ALUOP_BUS_W-1:0] aluop_i,
    input  logic [ADDR_W-1:0]      mem_addr_i,
    input  logic [REG_BUS_W-1:0]   reg2_i,
    input  logic [REG_ADDR_W-1:0]  wd_i,
    input  logic                   wreg_i,
    input  logic [REG_BUS_W-1:0]   wdata_i,
    input  logic [ADDR_W-1:0]      inst_pc_i,
    input  logic                   flush_i,
    mem_stage_if.master            dbus,
    output logic                   out_valid_o,
    output logic [REG_ADDR_W-1:0]  wd_o,
    output logic                   wreg_o,
    output logic [REG_BUS_W-1:0]   wdata_o,
    output logic [ADDR_W-1:0]      inst_pc_o,
    output logic                   ale_o,
    output logic                   stallreq_o
);
    state_e                 state_q;
    logic                   req_q, we_q, valid_q, ale_q, wreg_q, owreg_q;
    logic [ADDR_W-1:0]      addr_q, pc_q, opc_q;
    logic [3:0]             wstrb_q;
    logic [DATA_W-1:0]      bwdata_q;
    logic [ALUOP_BUS_W-1:0] op_q;
    logic [1:0]             lo_q;
    logic [REG_ADDR_W-1:0]  wd_q, owd_q;
    logic [REG_BUS_W-1:0]   owdata_q;
    logic                   idle, accept, mem_op, mis;
    logic [3:0]             wstrb;
    logic [DATA_W-1:0]      wdata, ldata;

    assign idle   = state_q == IDLE;
    assign accept = idle & in_valid_i & ~flush_i;
    assign mem_op = is_mem_op(aluop_i);

    // In IDLE the aligner steers the incoming store; while busy it extracts the latched load.
    mem_align u_align (
        .op_i        (idle ? aluop_i : op_q),
        .addr_i      (idle ? mem_addr_i[1:0] : lo_q),
        .reg2_i      (reg2_i),
        .rdata_i     (dbus.dbus_rdata_i),
        .wstrb_o     (wstrb),
        .wdata_o     (wdata),
        .ldata_o     (ldata),
        .misaligned_o(mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            bwdata_q <= '0;
            op_q     <= '0;
            lo_q     <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            ale_q    <= 1'b0;
            owd_q    <= '0;
            owreg_q  <= 1'b0;
            owdata_q <= '0;
            opc_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            ale_q   <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    if (mem_op && !mis) begin
                        state_q  <= BUSY;
                        req_q    <= 1'b1;
                        we_q     <= is_store_op(aluop_i);
                        addr_q   <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        wstrb_q  <= wstrb;
                        bwdata_q <= wdata;
                        op_q     <= aluop_i;
                        lo_q     <= mem_addr_i[1:0];
                        wd_q     <= wd_i;
                        wreg_q   <= wreg_i & ~is_store_op(aluop_i);
                        pc_q     <= inst_pc_i;
                    end else begin
                        // Misaligned accesses report the faulting address in place of data.
                        valid_q  <= 1'b1;
                        ale_q    <= mem_op;
                        owd_q    <= wd_i;
                        owreg_q  <= wreg_i & ~mem_op;
                        owdata_q <= mem_op ? mem_addr_i : wdata_i;
                        opc_q    <= inst_pc_i;
                    end
                end
                BUSY: if (dbus.dbus_ack_i) begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    if (!flush_i) begin
                        valid_q  <= 1'b1;
                        owd_q    <= wd_q;
                        owreg_q  <= wreg_q;
                        owdata_q <= ldata;
                        opc_q    <= pc_q;
                    end
                end else if (flush_i) begin
                    state_q <= DRAIN;
                end
                DRAIN: if (dbus.dbus_ack_i) begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o        = idle;
    assign stallreq_o        = ~idle;
    assign dbus.dbus_req_o   = req_q;
    assign dbus.dbus_we_o    = we_q;
    assign dbus.dbus_addr_o  = addr_q;
    assign dbus.dbus_wstrb_o = wstrb_q;
    assign dbus.dbus_wdata_o = bwdata_q;
    assign out_valid_o       = valid_q;
    assign wd_o              = owd_q;
    assign wreg_o            = owreg_q;
    assign wdata_o           = owdata_q;
    assign inst_pc_o         = opc_q;
    assign ale_o             = ale_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a byte-level memory reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, wreg, flush, out_valid, wreg_o, ale, stallreq;
    logic [7:0]  aluop;
    logic [31:0] mem_addr, reg2, wdata, inst_pc, wdata_o, pc_o;
    logic [4:0]  wd, wd_o;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_b [64];
    logic [31:0] slv [16];
    localparam logic [31:0] BASE = 32'h0000_4000;

    mem_stage_if bus ();

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2), .wd_i(wd),
        .wreg_i(wreg), .wdata_i(wdata), .inst_pc_i(inst_pc), .flush_i(flush),
        .dbus(bus.master), .out_valid_o(out_valid), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .inst_pc_o(pc_o), .ale_o(ale), .stallreq_o(stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] wdv, input logic [31:0] pc, input logic [4:0] wdn,
                         input logic wr, input logic fl);
        aluop = op; mem_addr = a; reg2 = r2; wdata = wdv; inst_pc = pc; wd = wdn; wreg = wr;
        flush = fl; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    // Holds the request for lat cycles checking stability, then acks for one cycle.
    task automatic bus_ack(input string tag, input int lat, input logic [31:0] rd);
        logic [68:0] snap;
        snap = {bus.dbus_we_o, bus.dbus_addr_o, bus.dbus_wstrb_o, bus.dbus_wdata_o};
        repeat (lat) begin
            @(negedge clk);
            chk({tag, "_hold"}, 32'(bus.dbus_req_o && !in_ready && stallreq && !out_valid &&
                snap === {bus.dbus_we_o, bus.dbus_addr_o, bus.dbus_wstrb_o, bus.dbus_wdata_o}), 1);
        end
        bus.dbus_ack_i = 1'b1; bus.dbus_rdata_i = rd;
        @(negedge clk);
        bus.dbus_ack_i = 1'b0; bus.dbus_rdata_i = $urandom;
    endtask

    function automatic int op_bytes(input logic [7:0] op);
        return (op == EXE_LD_B_OP || op == EXE_LD_BU_OP || op == EXE_ST_B_OP) ? 1
             : (op == EXE_LD_H_OP || op == EXE_LD_HU_OP || op == EXE_ST_H_OP) ? 2
             : (op == EXE_LD_W_OP || op == EXE_ST_W_OP) ? 4 : 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input int a);
        int n = op_bytes(op);
        logic [31:0] v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_b[a + k]) << (8 * k));
        if ((op == EXE_LD_B_OP || op == EXE_LD_H_OP) && v >= (32'd1 << (8 * n - 1)))
            v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] rep(input logic [31:0] r2, input int n);
        return n == 1 ? (r2 & 32'hff) * 32'h0101_0101 : n == 2 ? (r2 & 32'hffff) * 32'h0001_0001 : r2;
    endfunction

    initial begin
        logic [7:0] ops [9];
        logic [7:0] op;
        logic [31:0] r2, pc, wdv, ea;
        logic [4:0] wdn;
        logic wr, mis, st;
        int n, a, lat;
        ops = '{EXE_ADD_OP, EXE_LD_B_OP, EXE_LD_H_OP, EXE_LD_W_OP, EXE_LD_BU_OP,
                EXE_LD_HU_OP, EXE_ST_B_OP, EXE_ST_H_OP, EXE_ST_W_OP};
        for (int i = 0; i < 64; i++) ref_b[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) slv[i] = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; aluop = '0; mem_addr = '0; reg2 = '0;
        wdata = '0; inst_pc = '0; wd = '0; wreg = 1'b0;
        bus.dbus_ack_i = 1'b0; bus.dbus_rdata_i = '0;
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_req", 32'({bus.dbus_req_o, bus.dbus_we_o, wreg_o, ale}), 0);
        chk("rst_data", wdata_o | bus.dbus_addr_o | bus.dbus_wdata_o | pc_o | 32'(wd_o) | 32'(bus.dbus_wstrb_o), 0);
        chk("rst_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b1;

        drive(EXE_ADD_OP, 32'h0, 32'h0, 32'h1234_5678, 32'h100, 5'd5, 1'b1, 1'b0);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_wdata", wdata_o, 32'h1234_5678);
        chk("add_wd", 32'(wd_o), 5);
        chk("add_wreg_pc", {31'(pc_o), wreg_o}, {31'(32'h100), 1'b1});
        chk("add_noreq", 32'(bus.dbus_req_o), 0);

        for (int u = 0; u < 2; u++) begin
            drive(u == 0 ? EXE_LD_B_OP : EXE_LD_BU_OP, 32'h1003, 32'h0, 32'h0, 32'h104, 5'd7, 1'b1, 1'b0);
            chk("ldb_req", 32'({bus.dbus_req_o, bus.dbus_we_o, bus.dbus_wstrb_o}), 32'b100000);
            chk("ldb_addr", bus.dbus_addr_o, 32'h1000);
            chk("ldb_ready", 32'(in_ready), 0);
            bus_ack("ldb", 3, 32'h80FF_7F01);
            chk("ldb_valid", 32'({out_valid, wreg_o, bus.dbus_req_o, in_ready}), 32'b1101);
            chk("ldb_wdata", wdata_o, u == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
        end

        drive(EXE_ST_H_OP, 32'h2002, 32'hAAAA_1234, 32'h0, 32'h108, 5'd9, 1'b1, 1'b0);
        chk("sth_we", 32'({bus.dbus_req_o, bus.dbus_we_o}), 3);
        chk("sth_strb", 32'(bus.dbus_wstrb_o), 32'b1100);
        chk("sth_wdata", bus.dbus_wdata_o, 32'h1234_1234);
        chk("sth_addr", bus.dbus_addr_o, 32'h2000);
        bus_ack("sth", 2, 32'h0);
        chk("sth_result", 32'({out_valid, wreg_o, ale}), 32'b100);

        drive(EXE_LD_W_OP, 32'h3001, 32'h0, 32'h0, 32'h10c, 5'd3, 1'b1, 1'b0);
        chk("ale_flags", 32'({out_valid, ale, wreg_o, bus.dbus_req_o}), 32'b1100);
        @(negedge clk);
        chk("ale_pulse", 32'({out_valid, ale}), 0);

        drive(EXE_ADD_OP, 32'h0, 32'h0, 32'h55, 32'h110, 5'd4, 1'b1, 1'b1);
        chk("flush_idle", 32'(out_valid), 0);

        drive(EXE_LD_W_OP, 32'h3000, 32'h0, 32'h0, 32'h114, 5'd6, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_req", 32'({bus.dbus_req_o, in_ready, out_valid}), 32'b100);
        bus_ack("drain", 2, 32'hDEAD_BEEF);
        chk("drain_done", 32'({bus.dbus_req_o, in_ready, out_valid}), 32'b010);

        drive(EXE_LD_W_OP, 32'h3000, 32'h0, 32'h0, 32'h118, 5'd6, 1'b1, 1'b0);
        flush = 1'b1; bus.dbus_ack_i = 1'b1; bus.dbus_rdata_i = 32'h1111_2222;
        @(negedge clk);
        flush = 1'b0; bus.dbus_ack_i = 1'b0;
        chk("flushack", 32'({bus.dbus_req_o, in_ready, out_valid}), 32'b010);

        drive(EXE_LD_W_OP, 32'h3000, 32'h0, 32'h0, 32'h11c, 5'd6, 1'b1, 1'b0);
        chk("arst_pre", 32'(bus.dbus_req_o), 1);
        #2 rst = 1'b0;
        #1 chk("arst_now", 32'({bus.dbus_req_o, out_valid, in_ready}), 32'b001);
        #1 rst = 1'b1;
        @(negedge clk);
        bus.dbus_ack_i = 1'b1; bus.dbus_rdata_i = 32'h7777_7777;
        @(negedge clk);
        bus.dbus_ack_i = 1'b0;
        chk("arst_stray", 32'({bus.dbus_req_o, out_valid}), 0);

        for (int t = 0; t < 80; t++) begin
            op = ops[$urandom_range(0, 8)];
            n = op_bytes(op);
            a = $urandom_range(0, 63);
            if (n > 1 && $urandom_range(0, 1) == 1) a = a - a % n;
            r2 = $urandom; pc = $urandom; wdv = $urandom; wdn = 5'($urandom_range(1, 31));
            wr = 1'($urandom_range(0, 1));
            mis = n > 1 && a % n != 0;
            st = op == EXE_ST_B_OP || op == EXE_ST_H_OP || op == EXE_ST_W_OP;
            ea = BASE + 32'(a);
            drive(op, ea, r2, wdv, pc, wdn, wr, 1'b0);
            if (n == 0 || mis) begin
                chk("rnd_direct", 32'({out_valid, ale, wreg_o, bus.dbus_req_o}), {28'b0, 1'b1, mis, n == 0 && wr, 1'b0});
                if (n == 0) chk("rnd_alu", wdata_o ^ 32'(wd_o), wdv ^ 32'(wdn));
            end else begin
                chk("rnd_req", 32'({bus.dbus_req_o, bus.dbus_we_o}), {30'b0, 1'b1, st});
                chk("rnd_addr", bus.dbus_addr_o, ea - ea % 4);
                chk("rnd_strb", 32'(bus.dbus_wstrb_o), st ? ((32'd1 << n) - 1) << (a % 4) : 0);
                if (st) begin
                    chk("rnd_wdata", bus.dbus_wdata_o, rep(r2, n));
                    for (int k = 0; k < 4; k++)
                        if (bus.dbus_wstrb_o[k]) slv[a / 4][8*k +: 8] = bus.dbus_wdata_o[8*k +: 8];
                    for (int k = 0; k < n; k++) ref_b[a + k] = 8'(r2 >> (8 * k));
                end
                lat = $urandom_range(0, 3);
                bus_ack("rnd", lat, slv[a / 4]);
                chk("rnd_result", 32'({out_valid, ale, wreg_o, bus.dbus_req_o, in_ready}),
                    {27'b0, 1'b1, 1'b0, !st && wr, 1'b0, 1'b1});
                chk("rnd_wd_pc", pc_o ^ 32'(wd_o), pc ^ 32'(wdn));
                if (!st) chk("rnd_load", wdata_o, ref_load(op, a));
            end
            @(negedge clk);
            chk("rnd_pulse", 32'(out_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
